brc_mc: RTL and testbench
=========================

Name: brc_mc

Overview:
- Multi-channel boot-record collector: successor to the fixed three-way CMS/IPM/CFG boot-record splitter.
- Captures the NVR boot-record row stream into NCH parametrised channels. Each channel owns a contiguous row window.
- Tracks per-channel row completeness and runs a completion/ready handshake per consumer.
- Substitutes per-channel defaults for missing rows at end of load, and reports duplicate/out-of-range rows and load timeout. Sits between the NVR loader and sysctrl consumers (CMS, IP trim, syscfg, and future consumers).

Parameters:
- BRC, 128: total boot-record row index space.
- BRCW, $clog2(BRC): row index width.
- BRDW, 256: row data width.
- NCH, 4: channel count (1..8).
- MAXR, 12: maximum rows per channel; sizes the storage.
- CH_BASE, brc_pkg::CH_BASE_DEF: NCH x BRCW packed array, first row index per channel.
- CH_CNT, brc_pkg::CH_CNT_DEF: NCH x 4-bit packed array, rows per channel, each 1..MAXR.
- TOW, 16: timeout counter width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous active-high reset.
- brvld, input, 1: row valid.
- bridx, input, BRCW: row index.
- brdat, input, BRDW: row data, sampled with brvld.
- brdone, input, 1: loader finished (single-cycle pulse).
- chdef, input, NCH x MAXR x BRDW: per-channel default row values.
- chdata, output, NCH x MAXR x BRDW: captured rows.
- chvld, output, NCH: channel data final (level).
- chset, output, NCH: one-cycle pulse on the cycle chvld rises.
- chready, input, NCH: consumer has applied its data.
- brready, output, NCH: per-channel ready returned to the loader.
- chmiss, output, NCH: channel finalised with at least one default row.
- err_dup, output, 1: sticky; a row was received twice.
- err_oor, output, 1: sticky; a row index maps to no channel.
- err_to, output, 1: sticky; load timed out.
- busy, output, 1: FSM not in IDLE or DONE.

Behaviour:
- Reset values: chdata=0, chvld=0, chset=0, brready=0, chmiss=0, all err_* = 0, busy=0, FSM=IDLE, row bitmaps cleared, timeout counter=0.
- Input pipeline: brvld, bridx and brdat are registered together through two stages (pl1, pl2). The row write occurs on the clock edge after pl2 is valid. A row presented in cycle T is visible on chdata at T+3.
- Channel match: row belongs to channel c if CH_BASE[c] <= idx < CH_BASE[c]+CH_CNT[c]. Slot = idx - CH_BASE[c], computed at BRCW bits. Lowest c wins on overlap; package constants shall not overlap.
- No match: err_oor is set and the row is dropped.
- Duplicate: if the row's bitmap bit is already set, err_dup is set and the new data overwrites (last write wins).
- Completion: a channel is complete when all of its CH_CNT bits are set. chvld[c] rises the cycle after the final bit is set. chset[c] pulses for that same single cycle.
- Finalise on brdone (brdone seen at stage pl2, so in-flight rows land first):
  - Each incomplete channel loads chdef into every missing slot in one cycle.
  - chmiss[c] is set, then chvld/chset follow as for a complete channel.
- brready[c] = chvld[c] & chready[c], combinational from registered chvld.
- FSM:
  - IDLE -> LOAD on the first brvld.
  - LOAD -> FIN on pl2 brdone, or on timeout (err_to set).
  - FIN -> WAITRDY after the one-cycle default fill.
  - WAITRDY -> DONE when all chvld & chready are true.
  - DONE is terminal until reset.
- Timeout counter: clears on each pl2 row; increments in LOAD; timeout when it reaches all-ones.
- Rows arriving in FIN, WAITRDY or DONE: ignored; err_dup is set if the row maps to a channel.
- Simultaneous final row and brdone at pl2: the row is written first, and that channel is not marked chmiss.
- chready before chvld: ignored; brready stays 0.
- Reset mid-load: all state cleared within the same cycle edge. Partial data is discarded and chvld=0.

Decomposition:
- brc_pkg holds:
  - CH_BASE_DEF and CH_CNT_DEF. Default map: ch0 base 0/cnt 1 (CMS), ch1 base 1/cnt 3 (IPM), ch2 base 4/cnt 12 (CFG), ch3 base 16/cnt 4 (spare).
  - FSM state enum.
  - Channel-index helper function.
- Sub-module brc_chan: one instance per channel. It holds storage, the bitmap, the complete/chmiss/chvld/chset logic and the default fill. The top level keeps the pipeline, decode, FSM and timeout.

Test Plan:
- Rows 0..19 in order, default map, chready all 1: chvld=4'hF at expected cycles; chset each 1 cycle; chmiss=0; brready=4'hF; DONE; no errors.
- Rows 0..15 only, then brdone: ch3 chdata = chdef[3]; chmiss=4'b1000; chvld=4'hF.
- Row 5 sent twice, with data A then B: chdata[2][1]=B; err_dup=1; completion is unaffected.
- Row index 100: err_oor=1, no storage changes. Then no further rows for 2^16 cycles: err_to=1, FSM reaches FIN, and all channels are filled with defaults.
- Row 19 and brdone at pl2 in the same cycle: ch3 complete with chmiss[3]=0. Then hold chready[1]=0: brready[1]=0, FSM stays in WAITRDY until chready[1] goes high.
- Assert reset after row 8: all outputs return to reset values the next cycle. Replaying rows 0..19 completes normally.

Source files
------------

// File: rtl/brc_pkg.sv
// Shared definitions for the boot-record collector: default channel map, FSM states, row-window test.
// Pure declarations; no timing and no flow control.
package brc_pkg;

    localparam int DEF_NCH  = 4;
    localparam int DEF_BRCW = 7;

    // ch0 CMS, ch1 IPM, ch2 CFG, ch3 spare; windows must not overlap
    localparam logic [DEF_NCH-1:0][DEF_BRCW-1:0] CH_BASE_DEF = {7'd16, 7'd4, 7'd1, 7'd0};
    localparam logic [DEF_NCH-1:0][3:0]          CH_CNT_DEF  = {4'd4, 4'd12, 4'd3, 4'd1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIN,
        ST_WAITRDY,
        ST_DONE
    } brc_state_t;

    // True when idx falls inside [base, base+cnt); 17-bit sum so the upper bound cannot wrap.
    function automatic logic in_window(input logic [15:0] idx,
                                       input logic [15:0] base,
                                       input logic [3:0]  cnt);
        logic [16:0] lim;
        lim = {1'b0, base} + {13'd0, cnt};
        return (idx >= base) && ({1'b0, idx} < lim);
    endfunction

endpackage

// File: rtl/brc_chan.sv
// One channel's row store: bitmap-tracked capture, one-cycle default fill, completion flags.
// Write lands on the edge after wr; vld rises one edge after the bitmap fills; rows are never backpressured.
module brc_chan
    import brc_pkg::*;
#(
    parameter int BRDW = 256,
    parameter int MAXR = 12,
    parameter int CNT  = 1,
    parameter int SLW  = $clog2(MAXR)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [SLW-1:0]            slot,
    input  logic [BRDW-1:0]           wdat,
    input  logic                      fill,
    input  logic [MAXR-1:0][BRDW-1:0] def,
    output logic [MAXR-1:0][BRDW-1:0] data,
    output logic                      vld,
    output logic                      set,
    output logic                      miss,
    output logic                      dup
);

    localparam logic [MAXR-1:0] MASK = MAXR'((64'd1 << CNT) - 64'd1);

    logic [MAXR-1:0] bm;
    logic            full;

    assign full = ((bm & MASK) == MASK);
    assign dup  = wr & bm[slot];

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            bm   <= '0;
            vld  <= 1'b0;
            set  <= 1'b0;
            miss <= 1'b0;
        end else begin
            if (wr) begin
                data[slot] <= wdat;
                bm[slot]   <= 1'b1;
            end else if (fill) begin
                // only slots the loader never delivered take the default
                for (int s = 0; s < MAXR; s++) begin
                    if (MASK[s] && !bm[s]) begin
                        data[s] <= def[s];
                    end
                end
                bm   <= MASK;
                miss <= !full;
            end
            vld <= vld | full;
            set <= full & ~vld;
        end
    end

endmodule

// File: rtl/brc_mc.sv
// Multi-channel boot-record collector: two-stage row pipeline, window decode, load FSM with timeout.
// Row at T visible on chdata at T+3; loader is never stalled, brready reports per-channel consumer handoff.
module brc_mc
    import brc_pkg::*;
#(
    parameter int BRC  = 128,
    parameter int BRCW = $clog2(BRC),
    parameter int BRDW = 256,
    parameter int NCH  = 4,
    parameter int MAXR = 12,
    parameter logic [NCH-1:0][BRCW-1:0] CH_BASE = CH_BASE_DEF,
    parameter logic [NCH-1:0][3:0]      CH_CNT  = CH_CNT_DEF,
    parameter int TOW  = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                brvld,
    input  logic [BRCW-1:0]                     bridx,
    input  logic [BRDW-1:0]                     brdat,
    input  logic                                brdone,
    input  logic [NCH-1:0][MAXR-1:0][BRDW-1:0]  chdef,
    output logic [NCH-1:0][MAXR-1:0][BRDW-1:0]  chdata,
    output logic [NCH-1:0]                      chvld,
    output logic [NCH-1:0]                      chset,
    input  logic [NCH-1:0]                      chready,
    output logic [NCH-1:0]                      brready,
    output logic [NCH-1:0]                      chmiss,
    output logic                                err_dup,
    output logic                                err_oor,
    output logic                                err_to,
    output logic                                busy
);

    localparam int SLW = $clog2(MAXR);

    brc_state_t      state;
    logic            p1_vld, p1_done, p2_vld, p2_done;
    logic [BRCW-1:0] p1_idx, p2_idx;
    logic [BRDW-1:0] p1_dat, p2_dat;
    logic [TOW-1:0]  to_cnt;
    logic [NCH-1:0]  match, hit, wr, dup;
    logic            accept, fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld  <= 1'b0;
            p1_done <= 1'b0;
            p1_idx  <= '0;
            p1_dat  <= '0;
            p2_vld  <= 1'b0;
            p2_done <= 1'b0;
            p2_idx  <= '0;
            p2_dat  <= '0;
        end else begin
            p1_vld  <= brvld;
            p1_done <= brdone;
            p1_idx  <= bridx;
            p1_dat  <= brdat;
            p2_vld  <= p1_vld;
            p2_done <= p1_done;
            p2_idx  <= p1_idx;
            p2_dat  <= p1_dat;
        end
    end

    // rows only land while loading; later arrivals are dropped but still flagged
    assign accept = p2_vld && ((state == ST_IDLE) || (state == ST_LOAD));
    assign fill   = (state == ST_FIN);
    assign hit    = match & (~match + NCH'(1));
    assign wr     = {NCH{accept}} & hit;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [BRCW-1:0] rel;

        assign match[c] = in_window(16'(p2_idx), 16'(CH_BASE[c]), CH_CNT[c]);
        assign rel      = p2_idx - CH_BASE[c];

        brc_chan #(
            .BRDW (BRDW),
            .MAXR (MAXR),
            .CNT  (int'(CH_CNT[c])),
            .SLW  (SLW)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .slot  (SLW'(rel)),
            .wdat  (p2_dat),
            .fill  (fill),
            .def   (chdef[c]),
            .data  (chdata[c]),
            .vld   (chvld[c]),
            .set   (chset[c]),
            .miss  (chmiss[c]),
            .dup   (dup[c])
        );
    end

    assign brready = chvld & chready;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_dup <= 1'b0;
            err_oor <= 1'b0;
        end else begin
            if (p2_vld && !(|match)) begin
                err_oor <= 1'b1;
            end
            if ((|dup) || (p2_vld && (|match) && !accept)) begin
                err_dup <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
            err_to <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (brvld) begin
                        state  <= ST_LOAD;
                        busy   <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    // brdone travels with the pipeline so in-flight rows are written first
                    if (p2_done) begin
                        state <= ST_FIN;
                    end else if ((&to_cnt) && !p2_vld) begin
                        state  <= ST_FIN;
                        err_to <= 1'b1;
                    end
                    if (p2_vld) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                ST_FIN: begin
                    state <= ST_WAITRDY;
                end
                ST_WAITRDY: begin
                    if (&(chvld & chready)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brc_mc.sv
// Randomized-data directed bench for brc_mc against a row-map/bitmap reference model.
// Expected data, flags and chvld rise cycles are derived from the row windows and pipeline depth.
module tb_brc_mc;

    localparam int NCH  = 4;
    localparam int MAXR = 12;
    localparam int BRDW = 256;
    localparam int BRCW = 7;

    logic                               clk = 1'b0;
    logic                               reset;
    logic                               brvld;
    logic [BRCW-1:0]                    bridx;
    logic [BRDW-1:0]                    brdat;
    logic                               brdone;
    logic [NCH-1:0][MAXR-1:0][BRDW-1:0] chdef;
    logic [NCH-1:0][MAXR-1:0][BRDW-1:0] chdata;
    logic [NCH-1:0]                     chvld, chset, chready, brready, chmiss;
    logic                               err_dup, err_oor, err_to, busy;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    int base_tab [NCH] = '{0, 1, 4, 16};
    int cnt_tab  [NCH] = '{1, 3, 12, 4};

    logic [BRDW-1:0] exp_dat [NCH][MAXR];
    bit              got     [NCH][MAXR];
    int              exp_rise [NCH];
    int              rise_cyc [NCH];
    int              set_cyc  [NCH];
    int              set_cnt  [NCH];
    logic [NCH-1:0]  exp_miss;
    logic            exp_dup, exp_oor, exp_to;
    logic [BRDW-1:0] dat_a, dat_b;

    brc_mc dut (
        .clk     (clk),
        .reset   (reset),
        .brvld   (brvld),
        .bridx   (bridx),
        .brdat   (brdat),
        .brdone  (brdone),
        .chdef   (chdef),
        .chdata  (chdata),
        .chvld   (chvld),
        .chset   (chset),
        .chready (chready),
        .brready (brready),
        .chmiss  (chmiss),
        .err_dup (err_dup),
        .err_oor (err_oor),
        .err_to  (err_to),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < NCH; c++) begin
            if (chvld[c] && rise_cyc[c] < 0) rise_cyc[c] = cyc;
            if (chset[c]) begin
                set_cnt[c]++;
                set_cyc[c] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [BRDW-1:0] obs, input logic [BRDW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BRDW-1:0] rnd();
        logic [BRDW-1:0] v;
        for (int i = 0; i < BRDW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int chan_of(input int idx);
        for (int c = 0; c < NCH; c++)
            if (idx >= base_tab[c] && idx < base_tab[c] + cnt_tab[c]) return c;
        return -1;
    endfunction

    function automatic bit chan_full(input int c);
        for (int s = 0; s < cnt_tab[c]; s++)
            if (!got[c][s]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < MAXR; s++) begin
                exp_dat[c][s] = '0;
                got[c][s]     = 1'b0;
            end
            exp_rise[c] = -1;
            rise_cyc[c] = -1;
            set_cyc[c]  = -1;
            set_cnt[c]  = 0;
        end
        exp_miss = '0;
        exp_dup  = 1'b0;
        exp_oor  = 1'b0;
        exp_to   = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        brvld  = 1'b0;
        bridx  = '0;
        brdat  = '0;
        brdone = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_clear();
    endtask

    // Missing slots take chdef; timing unknown (k < 0) after a timeout.
    task automatic finalize(input int k);
        for (int c = 0; c < NCH; c++) begin
            if (!chan_full(c)) begin
                exp_miss[c] = 1'b1;
                for (int s = 0; s < cnt_tab[c]; s++) begin
                    if (!got[c][s]) begin
                        exp_dat[c][s] = chdef[c][s];
                        got[c][s]     = 1'b1;
                    end
                end
                exp_rise[c] = (k < 0) ? -2 : k + 5;
            end else if (k < 0) begin
                exp_rise[c] = -2;
            end
        end
    endtask

    task automatic send_row(input int idx, input logic [BRDW-1:0] d, input bit done);
        int c;
        brvld  = 1'b1;
        bridx  = BRCW'(idx);
        brdat  = d;
        brdone = done;
        c = chan_of(idx);
        if (c < 0) begin
            exp_oor = 1'b1;
        end else begin
            if (got[c][idx - base_tab[c]]) exp_dup = 1'b1;
            exp_dat[c][idx - base_tab[c]] = d;
            got[c][idx - base_tab[c]]     = 1'b1;
            if (exp_rise[c] < 0 && chan_full(c)) exp_rise[c] = cyc + 4;
        end
        if (done) finalize(cyc);
        step();
        brvld  = 1'b0;
        brdone = 1'b0;
    endtask

    task automatic send_done();
        brdone = 1'b1;
        finalize(cyc);
        step();
        brdone = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check({tag, " busy"}, busy, '0);
    endtask

    task automatic verify_final(input string tag);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < MAXR; s++)
                check($sformatf("%s chdata[%0d][%0d]", tag, c, s), chdata[c][s], exp_dat[c][s]);
        check({tag, " chvld"}, chvld, 4'hF);
        check({tag, " chmiss"}, chmiss, exp_miss);
        check({tag, " brready"}, brready, 4'hF);
        check({tag, " err_dup"}, err_dup, exp_dup);
        check({tag, " err_oor"}, err_oor, exp_oor);
        check({tag, " err_to"}, err_to, exp_to);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s chset count %0d", tag, c), set_cnt[c], 1);
            if (exp_rise[c] != -2) begin
                check($sformatf("%s chvld rise %0d", tag, c), rise_cyc[c], exp_rise[c]);
                check($sformatf("%s chset cycle %0d", tag, c), set_cyc[c], exp_rise[c]);
            end
        end
    endtask

    initial begin
        chready = '1;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < MAXR; s++) chdef[c][s] = rnd();
        do_reset();

        check("rst chvld", chvld, '0);
        check("rst chset", chset, '0);
        check("rst chdata", |chdata, '0);
        check("rst chmiss", chmiss, '0);
        check("rst brready", brready, '0);
        check("rst busy", busy, '0);
        check("rst errs", {err_dup, err_oor, err_to}, '0);

        // full in-order load
        for (int i = 0; i < 20; i++) begin
            send_row(i, rnd(), 1'b0);
            if (i == 1) begin
                check("t1 early brready", brready, '0);
                check("t1 busy in load", busy, 1);
            end
        end
        send_done();
        wait_idle("t1");
        verify_final("t1");

        // ch3 never delivered
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < MAXR; s++) chdef[c][s] = rnd();
        do_reset();
        for (int i = 0; i < 16; i++) send_row(i, rnd(), 1'b0);
        send_done();
        wait_idle("t2");
        verify_final("t2");
        check("t2 chmiss", chmiss, 4'b1000);

        // duplicate row 5
        do_reset();
        dat_a = rnd();
        dat_b = rnd();
        for (int i = 0; i < 5; i++) send_row(i, rnd(), 1'b0);
        send_row(5, dat_a, 1'b0);
        send_row(5, dat_b, 1'b0);
        for (int i = 6; i < 20; i++) send_row(i, rnd(), 1'b0);
        send_done();
        wait_idle("t3");
        verify_final("t3");
        check("t3 dup data", chdata[2][1], dat_b);
        check("t3 err_dup", err_dup, 1);

        // out-of-range row, then silence until timeout
        do_reset();
        send_row(100, rnd(), 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("t4 err_oor", err_oor, 1);
        check("t4 no store", |chdata, '0);
        check("t4 busy", busy, 1);
        for (int i = 0; i < 60000; i++) step();
        check("t4 early err_to", err_to, '0);
        begin
            int n = 0;
            while (!err_to && n < 8000) begin
                step();
                n++;
            end
        end
        check("t4 err_to", err_to, 1);
        exp_to = 1'b1;
        finalize(-1);
        wait_idle("t4");
        verify_final("t4");
        check("t4 chmiss", chmiss, 4'hF);

        // final row with brdone, then withheld chready[1]
        do_reset();
        chready = 4'b1101;
        for (int i = 0; i < 19; i++) send_row(i, rnd(), 1'b0);
        send_row(19, rnd(), 1'b1);
        for (int i = 0; i < 10; i++) step();
        check("t5 brready held", brready, 4'b1101);
        check("t5 waitrdy busy", busy, 1);
        check("t5 chmiss", chmiss, '0);
        chready = '1;
        wait_idle("t5");
        verify_final("t5");

        // reset mid-load, then replay
        do_reset();
        for (int i = 0; i < 9; i++) send_row(i, rnd(), 1'b0);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        check("t6 rst chvld", chvld, '0);
        check("t6 rst chdata", |chdata, '0);
        check("t6 rst chmiss", chmiss, '0);
        check("t6 rst chset", chset, '0);
        check("t6 rst brready", brready, '0);
        check("t6 rst busy", busy, '0);
        check("t6 rst errs", {err_dup, err_oor, err_to}, '0);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 20; i++) send_row(i, rnd(), 1'b0);
        send_done();
        wait_idle("t6");
        verify_final("t6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
